// File: rtl/multi_edge_detect_if.sv
// Signal bundle for the multi-channel edge detector: raw inputs and controls
// towards the detector, per-channel pulse/status flags back from it.
interface multi_edge_detect_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] in;
  logic [1:0]          mode;
  logic [CHANNELS-1:0] clr_missed;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] missed;

  modport master (
    output in, mode, clr_missed,
    input  out, busy, missed
  );

  modport slave (
    input  in, mode, clr_missed,
    output out, busy, missed
  );
endinterface

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: synchronised inputs, selectable edge polarity,
// one-cycle pulse per edge followed by a TIMEOUT-cycle holdoff with a sticky missed flag.
module multi_edge_detect #(
  parameter int CHANNELS    = 4,
  parameter int TIMEOUT     = 20,
  parameter int SYNC_STAGES = 2,
  parameter int CTR_WIDTH   = $clog2(TIMEOUT + 1)
) (
  input logic                clk,
  input logic                n_reset,
  multi_edge_detect_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ASSERT  = 2'b01,
    HOLDOFF = 2'b10
  } state_t;

  localparam logic [CTR_WIDTH-1:0] CTR_LAST = CTR_WIDTH'(TIMEOUT - 1);

  logic [CHANNELS-1:0] sync_reg [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_reg;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] out_vec;
  logic [CHANNELS-1:0] busy_vec;
  logic [CHANNELS-1:0] missed_vec;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= '0;
      end
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= bus.in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_reg[k] <= sync_reg[k-1];
      end
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & prev_reg;

  // Mode is applied to the edge seen this cycle, so a change affects only later edges.
  always_comb begin
    qual = '0;
    case (bus.mode)
      2'b00:   qual = rise;
      2'b01:   qual = fall;
      2'b10:   qual = rise | fall;
      default: qual = '0;
    endcase
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    state_t               state_reg;
    state_t               state_next;
    logic [CTR_WIDTH-1:0] ctr_reg;
    logic [CTR_WIDTH-1:0] ctr_next;
    logic                 missed_reg;
    logic                 missed_next;

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        state_reg  <= IDLE;
        ctr_reg    <= '0;
        missed_reg <= 1'b0;
      end else begin
        state_reg  <= state_next;
        ctr_reg    <= ctr_next;
        missed_reg <= missed_next;
      end
    end

    always_comb begin
      state_next  = IDLE;
      ctr_next    = '0;
      missed_next = missed_reg;
      case (state_reg)
        IDLE: begin
          if (qual[gi]) begin
            state_next = ASSERT;
          end
        end
        ASSERT: begin
          state_next = HOLDOFF;
        end
        HOLDOFF: begin
          if (ctr_reg != CTR_LAST) begin
            state_next = HOLDOFF;
            ctr_next   = ctr_reg + CTR_WIDTH'(1);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
      // Set is evaluated after clear so a dropped edge always leaves a trace.
      if (bus.clr_missed[gi]) begin
        missed_next = 1'b0;
      end
      if (qual[gi] && (state_reg == ASSERT || state_reg == HOLDOFF)) begin
        missed_next = 1'b1;
      end
    end

    assign out_vec[gi]    = (state_reg == ASSERT);
    assign busy_vec[gi]   = (state_reg != IDLE);
    assign missed_vec[gi] = missed_reg;
  end

  assign bus.out    = out_vec;
  assign bus.busy   = busy_vec;
  assign bus.missed = missed_vec;

endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Multi-channel, parametrised edge detector with selectable edge polarity, input synchronisation and a per-channel holdoff window. Each channel emits a single-cycle pulse on a qualifying edge of its input, then ignores further edges for `TIMEOUT` cycles. Edges that arrive during holdoff are flagged in a sticky `missed` bit. It sits between asynchronous front-end comparator outputs and the delay-line timing logic, replacing the single-channel, rising-only detector.

## Interface

- `CHANNELS`, 4: number of independent input channels (≥1).
- `TIMEOUT`, 20: holdoff length in clock cycles after each pulse (≥1).
- `SYNC_STAGES`, 2: synchroniser flop depth per channel (≥1).
- `CTR_WIDTH`, `$clog2(TIMEOUT+1)`: derived holdoff counter width; not to be overridden.

- `clk` input 1: single clock; all state is on its rising edge.
- `n_reset` input 1: asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clk` externally.
- `in` input `CHANNELS`: raw asynchronous inputs, bit i = channel i.
- `mode` input 2: global edge select: 00 rising, 01 falling, 10 both, 11 disabled. Sampled every cycle.
- `clr_missed` input `CHANNELS`: per-channel clear of the `missed` flag, level-sensitive, synchronous.
- `out` output `CHANNELS`: one-cycle detection pulse per channel.
- `busy` output `CHANNELS`: high while the channel is in ASSERT or HOLDOFF.
- `missed` output `CHANNELS`: sticky flag; a qualifying edge was dropped during ASSERT/HOLDOFF.

## Operation

- Per channel: `SYNC_STAGES` flop chain `s`, then history flop `prev`. rise = s_last & ~prev; fall = ~s_last & prev.
- Qualifying edge `q`: rise (mode 00), fall (01), rise|fall (10), never (11).
- Per-channel FSM, 2-bit state, plus counter `ctr`:
  - IDLE: if `q`, go to ASSERT. `ctr` = 0.
  - ASSERT: `out`=1. Unconditionally go to HOLDOFF with `ctr` = 0.
  - HOLDOFF: `ctr` increments each cycle. When `ctr` == TIMEOUT-1, go to IDLE next cycle.
  - Unused encoding: go to IDLE.
- `busy` = (state != IDLE). `out` = (state == ASSERT), decoded from registered state.
- `missed[i]`: set on `q` while the state is ASSERT or HOLDOFF. Cleared when `clr_missed[i]`=1. If set and clear happen in the same cycle, set wins. Dropped edges are never queued.
- `mode` changes take effect on the next cycle's `q` evaluation. They never abort an ASSERT/HOLDOFF in progress.
- Mode 11: no new detections and no `missed` sets. Channels already in holdoff run to completion.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses.
- Reset values: all sync flops, `prev`, `ctr` = 0; state = IDLE; `out`, `busy`, `missed` = 0.
- Reset asserted mid-holdoff clears everything immediately. No pulse or `missed` state survives reset.
- An input already high at reset release is seen as a rising edge once it propagates through the synchroniser. This is intended.

## Timing

- Latency: let the input change be first captured by sync stage 1 at edge E0. Then `out` is high for exactly the cycle after edge E0+SYNC_STAGES.
- Holdoff: ASSERT lasts 1 cycle, then HOLDOFF lasts exactly TIMEOUT cycles. `busy` is high for TIMEOUT+1 cycles.
- Minimum spacing between consecutive `out` pulses on one channel: TIMEOUT+2 cycles. This applies when a qualifying edge is present in the first IDLE cycle.
- An edge whose detection cycle coincides with the last HOLDOFF cycle sets `missed` and is not detected.
- `missed` rises the cycle after the offending `q`. It falls the cycle after `clr_missed` is sampled high.

## Test plan

- Reset: hold `n_reset`=0 with `in`=4'hF, then release with `in`=0. Require `out`=`busy`=`missed`=0 throughout. Separately, pull `n_reset` low mid-holdoff: all outputs go 0 before the next `clk` edge.
- Rising latency/holdoff (mode 00, CH0): drive 0→1 captured at E0. Require `out[0]` high only in the cycle after E2. Require `busy[0]` high for exactly 21 cycles, and no pulse on falling edges.
- Modes: on CH1, apply a 50-cycle high pulse under each mode. Mode 00 gives 1 pulse at the rise. Mode 01 gives 1 pulse at the fall. Mode 10 gives 2 pulses 50 cycles apart. Mode 11 gives 0 pulses and `missed[1]` stays 0.
- Missed/clear: in mode 10, toggle CH2 every 5 cycles for 30 cycles. Require a first pulse only, then next pulse ≥22 cycles later, and `missed[2]`=1. Assert `clr_missed[2]` with a concurrent dropped edge: `missed[2]` stays 1. Clear with no edge: `missed[2]`=0.
- Spacing boundary: in mode 00, place a rising edge detected in the last HOLDOFF cycle: require no pulse and `missed`=1. Place one in the first IDLE cycle: require a pulse exactly 22 cycles after the previous one.
- Independence: simultaneous rising edges on all 4 channels give `out`=4'hF in one cycle. Staggering CH3 by 7 cycles gives independent `busy` windows.
